// File: rtl/ex_hazard_scoreboard.sv
// DE/EX read-after-write scoreboard: per-destination countdowns for scalar, vector and CC
// writes in flight between issue and writeback, plus the DE stall and EX accept decisions.
module ex_hazard_scoreboard #(
    parameter int PIPE_DEPTH    = 3,
    parameter int NUM_RF        = 16,
    parameter int NUM_VRF       = 64,
    parameter int VREG_ID_WIDTH = 6
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_Issue,
    input  logic                     I_RegWEn,
    input  logic [3:0]               I_DestRegIdx,
    input  logic                     I_VRegWEn,
    input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
    input  logic                     I_CCWEn,
    input  logic                     I_Src1Valid,
    input  logic                     I_Src2Valid,
    input  logic [3:0]               I_Src1RegIdx,
    input  logic [3:0]               I_Src2RegIdx,
    input  logic                     I_VSrc1Valid,
    input  logic                     I_VSrc2Valid,
    input  logic [VREG_ID_WIDTH-1:0] I_VSrc1Idx,
    input  logic [VREG_ID_WIDTH-1:0] I_VSrc2Idx,
    input  logic                     I_CCRead,
    input  logic                     I_GPUStallSignal,
    input  logic                     I_Flush,
    output logic                     O_DEStall,
    output logic                     O_Accept,
    output logic [NUM_RF-1:0]        O_RegBusy,
    output logic                     O_CCBusy,
    output logic [4:0]               O_NumPending
);

    localparam logic [2:0] DEPTH_C = 3'(PIPE_DEPTH);

    logic [2:0]        sc_r [NUM_RF];
    logic [2:0]        vc_r [NUM_VRF];
    logic [2:0]        ccc_r;
    logic [2:0]        sc_nxt_s [NUM_RF];
    logic [2:0]        vc_nxt_s [NUM_VRF];
    logic [2:0]        ccc_nxt_s;
    logic [NUM_RF-1:0] busy_nxt_s;
    logic [4:0]        pend_nxt_s;
    logic              hazard_s;
    logic [NUM_RF-1:0] reg_busy_r;
    logic              cc_busy_r;
    logic [4:0]        num_pending_r;

    // RAW check against pre-edge counters; a value of 1 still stalls since there is no bypass.
    always_comb begin
        hazard_s = (I_Src1Valid  && (sc_r[I_Src1RegIdx] != 3'd0))
                || (I_Src2Valid  && (sc_r[I_Src2RegIdx] != 3'd0))
                || (I_VSrc1Valid && (vc_r[I_VSrc1Idx]   != 3'd0))
                || (I_VSrc2Valid && (vc_r[I_VSrc2Idx]   != 3'd0))
                || (I_CCRead     && (ccc_r              != 3'd0));
    end

    assign O_DEStall = I_Issue & (hazard_s | I_GPUStallSignal);
    assign O_Accept  = I_Issue & ~hazard_s & ~I_GPUStallSignal & ~I_Flush & ~I_RESET;

    // Scalar counter next state: freeze, reload on accepted write, else count down.
    always_comb begin
        for (int i = 0; i < NUM_RF; i++) begin
            sc_nxt_s[i] = sc_r[i];
            if (I_GPUStallSignal) begin
                sc_nxt_s[i] = sc_r[i];
            end else if (O_Accept && I_RegWEn && (I_DestRegIdx == 4'(i))) begin
                sc_nxt_s[i] = DEPTH_C;
            end else if (sc_r[i] != 3'd0) begin
                sc_nxt_s[i] = sc_r[i] - 3'd1;
            end else begin
                sc_nxt_s[i] = 3'd0;
            end
        end
    end

    // Vector counter next state, same rules as the scalar file.
    always_comb begin
        for (int i = 0; i < NUM_VRF; i++) begin
            vc_nxt_s[i] = vc_r[i];
            if (I_GPUStallSignal) begin
                vc_nxt_s[i] = vc_r[i];
            end else if (O_Accept && I_VRegWEn && (I_DestVRegIdx == VREG_ID_WIDTH'(i))) begin
                vc_nxt_s[i] = DEPTH_C;
            end else if (vc_r[i] != 3'd0) begin
                vc_nxt_s[i] = vc_r[i] - 3'd1;
            end else begin
                vc_nxt_s[i] = 3'd0;
            end
        end
    end

    // CC counter next state.
    always_comb begin
        ccc_nxt_s = ccc_r;
        if (I_GPUStallSignal) begin
            ccc_nxt_s = ccc_r;
        end else if (O_Accept && I_CCWEn) begin
            ccc_nxt_s = DEPTH_C;
        end else if (ccc_r != 3'd0) begin
            ccc_nxt_s = ccc_r - 3'd1;
        end else begin
            ccc_nxt_s = 3'd0;
        end
    end

    // Post-edge busy mask and pending count, registered so outputs have no input path.
    always_comb begin
        busy_nxt_s = {NUM_RF{1'b0}};
        pend_nxt_s = 5'd0;
        for (int i = 0; i < NUM_RF; i++) begin
            busy_nxt_s[i] = (sc_nxt_s[i] != 3'd0);
            pend_nxt_s    = pend_nxt_s + 5'(busy_nxt_s[i]);
        end
    end

    // State register; reset overrides any issue or flush on the same edge.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_RF; i++) begin
                sc_r[i] <= 3'd0;
            end
            for (int i = 0; i < NUM_VRF; i++) begin
                vc_r[i] <= 3'd0;
            end
            ccc_r         <= 3'd0;
            reg_busy_r    <= {NUM_RF{1'b0}};
            cc_busy_r     <= 1'b0;
            num_pending_r <= 5'd0;
        end else begin
            for (int i = 0; i < NUM_RF; i++) begin
                sc_r[i] <= sc_nxt_s[i];
            end
            for (int i = 0; i < NUM_VRF; i++) begin
                vc_r[i] <= vc_nxt_s[i];
            end
            ccc_r         <= ccc_nxt_s;
            reg_busy_r    <= busy_nxt_s;
            cc_busy_r     <= (ccc_nxt_s != 3'd0);
            num_pending_r <= pend_nxt_s;
        end
    end

    assign O_RegBusy    = reg_busy_r;
    assign O_CCBusy     = cc_busy_r;
    assign O_NumPending = num_pending_r;

endmodule

// File: doc/ex_hazard_scoreboard.md
Name: ex_hazard_scoreboard

Overview:
- Tracks in-flight register, vector-register and CC writes between DE and WB, and produces the DE-stage stall for read-after-write hazards.
- Owns the "may this instruction enter Execute" decision, sequencing issue into the Execute datapath.
- Each destination gets a countdown set to the pipeline distance to writeback. Sources that hit a nonzero counter stall DE.
- Counters freeze while the GPU stage stalls. A taken branch squashes the same-cycle issue.

Parameters:
- PIPE_DEPTH, 3: edges from EX issue until the write is visible in the RF (EX, MEM, WB). Legal range 1..7.
- NUM_RF, 16: scalar registers.
- NUM_VRF, 64: vector registers.
- VREG_ID_WIDTH, 6: vector index width.

Ports:
- I_CLOCK  in  1  clock. All state updates on negedge I_CLOCK.
- I_RESET  in  1  synchronous, active-high reset.
- I_Issue  in  1  DE presents a valid instruction for EX this cycle.
- I_RegWEn  in  1  issuing instruction writes a scalar register.
- I_DestRegIdx  in  4  scalar destination.
- I_VRegWEn  in  1  issuing instruction writes a vector register.
- I_DestVRegIdx  in  VREG_ID_WIDTH  vector destination.
- I_CCWEn  in  1  issuing instruction writes CC.
- I_Src1Valid, I_Src2Valid  in  1 each  scalar source used.
- I_Src1RegIdx, I_Src2RegIdx  in  4 each  scalar sources.
- I_VSrc1Valid, I_VSrc2Valid  in  1 each  vector source used.
- I_VSrc1Idx, I_VSrc2Idx  in  VREG_ID_WIDTH each  vector sources.
- I_CCRead  in  1  instruction reads CC (branches).
- I_GPUStallSignal  in  1  downstream stall; pipeline frozen.
- I_Flush  in  1  taken branch/jump resolved in EX; DE instruction is wrong-path.
- O_DEStall  out  1  combinational; DE must hold its instruction.
- O_Accept  out  1  combinational; issue is taken this cycle.
- O_RegBusy  out  NUM_RF  registered; bit i set while scalar counter i is nonzero.
- O_CCBusy  out  1  registered; CC counter nonzero.
- O_NumPending  out  5  registered; count of nonzero scalar counters (0..16).

Behaviour:
- State:
  - scalar counters SC[0..NUM_RF-1], vector counters VC[0..NUM_VRF-1], CC counter CCC.
  - Each counter is 3 bits wide.
  - "Busy" means the counter is nonzero.
- Hazard (combinational) is the OR of:
  - (I_Src1Valid & SC[I_Src1RegIdx]!=0)
  - (I_Src2Valid & SC[I_Src2RegIdx]!=0)
  - (I_VSrc1Valid & VC[I_VSrc1Idx]!=0)
  - (I_VSrc2Valid & VC[I_VSrc2Idx]!=0)
  - (I_CCRead & CCC!=0)
- Bypass: none. Counter value 1 still stalls, because the write lands at that edge.
- O_DEStall = I_Issue & (hazard | I_GPUStallSignal). It is 0 when I_Issue=0.
- O_Accept = I_Issue & ~hazard & ~I_GPUStallSignal & ~I_Flush & ~I_RESET.
- Per-edge update, in priority order:
  1. I_RESET: all counters 0. O_RegBusy=0, O_CCBusy=0, O_NumPending=0. This overrides any issue or flush, including mid-operation.
  2. I_GPUStallSignal: all counters hold. No issue is accepted, and I_Flush has no effect on counters.
  3. Otherwise, every nonzero counter decrements by 1. Then, if O_Accept:
     - I_RegWEn sets SC[I_DestRegIdx]=PIPE_DEPTH.
     - I_VRegWEn sets VC[I_DestVRegIdx]=PIPE_DEPTH.
     - I_CCWEn sets CCC=PIPE_DEPTH.
     - Set wins over decrement on the same entry (WAW reload).
- Writes to R15/PC through the branch path are not tracked. I_RegWEn governs only scalar RF writes.
- I_Flush:
  - Only blocks acceptance of the current DE instruction.
  - Older in-flight entries are not cleared, since they are already-committed older instructions.
- Busy lifetime: an issue accepted at edge N keeps the dest busy for the cycles after edges N..N+PIPE_DEPTH-1. It is free after edge N+PIPE_DEPTH, plus one edge per frozen edge in between.
- O_RegBusy, O_CCBusy and O_NumPending reflect counters after the edge, i.e. registered, zero combinational path from inputs.
- Out-of-range indices cannot occur (full-width fields).
- Simultaneous issue with src==dest of the same instruction: hazard uses the pre-edge counter, so there is no self-stall.

Test Plan:
- Reset mid-operation:
  - Stimulus: accept a write to R3, then assert I_RESET at the next edge.
  - Required: O_RegBusy=0, O_NumPending=0, and a following read of R3 does not stall.
- RAW stall, PIPE_DEPTH=3:
  - Stimulus: accept ADD writing R3 at edge 0; DE then presents a read of R3.
  - Required: O_DEStall=1 for the cycles after edges 0, 1 and 2, falling to 0 after edge 3; O_Accept=1 in that cycle.
- GPU freeze:
  - Stimulus: as the RAW stall scenario, with I_GPUStallSignal high for 2 edges starting after edge 1.
  - Required: R3 is busy until after edge 5; O_NumPending holds at 1 during the freeze.
- Flush:
  - Stimulus: I_Issue=1 and I_Flush=1 with a write to R5.
  - Required: O_Accept=0 and SC[5] stays 0. A prior in-flight R2 entry continues to count down normally.
- WAW reload and count:
  - Stimulus: accept R4 at edge 0 and again at edge 1; accept R7 at edge 1.
  - Required: O_NumPending=2 after edge 1; R4 free only after edge 4.
- CC and vector hazards:
  - CMP (I_CCWEn) followed by BRZ (I_CCRead) stalls until CCC=0.
  - VADD writing V10 followed by a V10 read stalls 3 cycles.
  - A V11 read does not stall.
